uart_oversampler: RTL and testbench

UART_OVERSAMPLER -- requirements
Module: uart_oversampler

---
 rtl/uart_oversampler.sv | 115 +++++++++++
 tb/tb_uart_oversampler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_oversampler.sv
// Oversampling UART bit recoverer: start-edge hunt, centred majority vote per bit.
// Optional noise flag under `UART_OVERSAMPLER_NOISE_EN`.
module uart_oversampler #(
    parameter int OSR    = 16,
    parameter int WIN_LO = 6,
    parameter int WIN_HI = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic hunt,
    input  logic in,
    output logic out,
    output logic valid
`ifdef UART_OVERSAMPLER_NOISE_EN
    ,
    output logic noise
`endif
);

    localparam int PH_W = $clog2(OSR);
    localparam int VC_W = $clog2(WIN_HI - WIN_LO + 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        SAMPLE = 1'b1
    } state_t;

    state_t            state, state_n;
    logic              sync1, s_in, prev;
    logic [PH_W-1:0]   phase, phase_n;
    logic [VC_W-1:0]   ones, ones_n, zeros, zeros_n;
    logic              out_n, valid_n, in_win;
`ifdef UART_OVERSAMPLER_NOISE_EN
    logic              noise_n;
`endif

    assign in_win = (int'(phase) >= WIN_LO) && (int'(phase) <= WIN_HI);

    always_comb begin
        state_n = state;
        phase_n = phase;
        ones_n  = ones;
        zeros_n = zeros;
        out_n   = out;
        valid_n = 1'b0;
`ifdef UART_OVERSAMPLER_NOISE_EN
        noise_n = 1'b0;
`endif
        if (hunt) begin
            state_n = HUNT;
            phase_n = '0;
            ones_n  = '0;
            zeros_n = '0;
        end else if (tick) begin
            if (state == HUNT) begin
                // The edge tick itself is phase 0 of the start bit.
                if (!s_in && prev) begin
                    state_n = SAMPLE;
                    phase_n = PH_W'(1);
                    ones_n  = '0;
                    zeros_n = '0;
                end
            end else if (phase == PH_LAST) begin
                out_n   = (ones > zeros);
                valid_n = 1'b1;
`ifdef UART_OVERSAMPLER_NOISE_EN
                noise_n = (ones != '0) && (zeros != '0);
`endif
                phase_n = '0;
                ones_n  = '0;
                zeros_n = '0;
            end else begin
                phase_n = phase + PH_W'(1);
                if (in_win) begin
                    if (s_in) ones_n  = ones + VC_W'(1);
                    else      zeros_n = zeros + VC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            phase <= '0;
            ones  <= '0;
            zeros <= '0;
            sync1 <= 1'b1;
            s_in  <= 1'b1;
            prev  <= 1'b1;
            out   <= 1'b1;
            valid <= 1'b0;
`ifdef UART_OVERSAMPLER_NOISE_EN
            noise <= 1'b0;
`endif
        end else begin
            sync1 <= in;
            s_in  <= sync1;
            // Edge history follows every tick, even while hunt is held.
            if (tick) prev <= s_in;
            state <= state_n;
            phase <= phase_n;
            ones  <= ones_n;
            zeros <= zeros_n;
            out   <= out_n;
            valid <= valid_n;
`ifdef UART_OVERSAMPLER_NOISE_EN
            noise <= noise_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_oversampler.sv
// Bench for uart_oversampler: sample-list reference model, directed cases then random frames.
module tb_uart_oversampler;

    localparam int OSR    = 16;
    localparam int WIN_LO = 6;
    localparam int WIN_HI = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic hunt = 1'b0;
    logic in = 1'b1;
    logic out, valid;
`ifdef UART_OVERSAMPLER_NOISE_EN
    logic noise;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: samples of the current bit, indexed by phase.
    bit m_hunting = 1'b1;
    bit m_prev = 1'b1;
    bit m_out = 1'b1;
    bit m_valid = 1'b0;
    bit m_noise = 1'b0;
    bit samples[$];

    int tick_no = 0;
    bit dut_vals[$];
    int dut_ticks[$];

    uart_oversampler #(.OSR(OSR), .WIN_LO(WIN_LO), .WIN_HI(WIN_HI)) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .hunt (hunt),
        .in   (in),
        .out  (out),
        .valid(valid)
`ifdef UART_OVERSAMPLER_NOISE_EN
        ,
        .noise(noise)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hunting = 1'b1;
        m_prev    = 1'b1;
        m_out     = 1'b1;
        m_valid   = 1'b0;
        m_noise   = 1'b0;
        samples.delete();
    endtask

    task automatic model_tick(input bit v, input bit h);
        int n1, n0;
        m_valid = 1'b0;
        m_noise = 1'b0;
        if (h) begin
            m_hunting = 1'b1;
            samples.delete();
        end else if (m_hunting) begin
            if (m_prev && !v) begin
                m_hunting = 1'b0;
                samples.delete();
                samples.push_back(v);
            end
        end else begin
            samples.push_back(v);
            if (samples.size() == OSR) begin
                n1 = 0;
                n0 = 0;
                for (int i = WIN_LO; i <= WIN_HI; i++) begin
                    if (samples[i]) n1++;
                    else n0++;
                end
                m_out   = (n1 > n0);
                m_valid = 1'b1;
                m_noise = (n1 != 0) && (n0 != 0);
                samples.delete();
            end
        end
        m_prev = v;
    endtask

    // One oversample period: hold in/hunt, gap cycles without tick, then the tick cycle.
    task automatic do_tick(input bit v, input bit h);
        int gap;
        gap  = $urandom_range(4, 2);
        in   = v;
        hunt = h;
        tick = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (g == 0) begin
                check("valid_one_cycle", valid, 1'b0);
                check("out_hold", out, m_out);
            end
        end
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        tick_no++;
        model_tick(v, h);
        check("valid", valid, m_valid);
        check("out", out, m_out);
`ifdef UART_OVERSAMPLER_NOISE_EN
        check("noise", noise, m_noise);
`endif
        if (valid === 1'b1) begin
            dut_vals.push_back(out);
            dut_ticks.push_back(tick_no);
        end
    endtask

    task automatic send_pattern(input logic [OSR-1:0] pat);
        for (int i = 0; i < OSR; i++) do_tick(pat[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input int flip_pct);
        logic [9:0] fr;
        bit v;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < OSR; i++) begin
                v = fr[k];
                if ($urandom_range(99, 0) < flip_pct) v = ~v;
                do_tick(v, ($urandom_range(199, 0) == 0));
            end
        end
    endtask

    task automatic pulse_reset();
        tick = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_out", out, 1'b1);
        check("rst_valid", valid, 1'b0);
`ifdef UART_OVERSAMPLER_NOISE_EN
        check("rst_noise", noise, 1'b0);
`endif
    endtask

    task automatic resync();
        do_tick(1'b1, 1'b1);
        do_tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0);
    endtask

    initial begin
        logic [9:0] fr55;
        int n_before;

        // Reset, with tick and hunt active to confirm reset dominates.
        tick = 1'b1;
        hunt = 1'b1;
        in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 1'b1);
        check("reset_valid", valid, 1'b0);
`ifdef UART_OVERSAMPLER_NOISE_EN
        check("reset_noise", noise, 1'b0);
`endif
        rst  = 1'b0;
        tick = 1'b0;
        hunt = 1'b0;
        in   = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b0);

        // Solid zero bit after a falling edge.
        send_pattern('0);
        resync();

        // Tie in the window, then glitches confined outside the window.
        send_pattern(16'h00C0);
        send_pattern(16'h03C0);
        resync();

        // 0x55 8N1: ten decisions alternating 0/1, one bit period apart.
        dut_vals.delete();
        dut_ticks.delete();
        send_frame(8'h55, 0);
        do_tick(1'b1, 1'b1);
        fr55 = {1'b1, 8'h55, 1'b0};
        check("frame_len", dut_vals.size(), 10);
        for (int k = 0; k < 10 && k < dut_vals.size(); k++) begin
            check("frame_bit", dut_vals[k], fr55[k]);
            if (k > 0) check("frame_spacing", dut_ticks[k] - dut_ticks[k-1], OSR);
        end
        resync();

        // hunt on the deciding tick suppresses the decision.
        n_before = dut_vals.size();
        for (int i = 0; i < OSR - 1; i++) do_tick(1'b0, 1'b0);
        do_tick(1'b0, 1'b1);
        check("hunt_no_valid", dut_vals.size(), n_before);
        for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0);
        send_pattern('0);
        resync();

        // Reset at phase 7 after a zero decision.
        send_pattern('0);
        for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b0);
        pulse_reset();
        n_before = dut_vals.size();
        for (int i = 0; i < 2 * OSR; i++) do_tick(1'b1, 1'b0);
        check("post_rst_no_valid", dut_vals.size(), n_before);

        // Random frames with sample noise and occasional hunt.
        for (int f = 0; f < 25; f++) begin
            send_frame(8'($urandom), (f < 5) ? 0 : 10);
            for (int i = 0; i < $urandom_range(20, 1); i++)
                do_tick(1'b1, ($urandom_range(29, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
